div_sequencer: RTL

- Iterative signed 32-bit divider controller. Time-multiplexes one external 4-cycle radix-2 restoring divide stage over 32 passes.
- On each pass it feeds the stage's A/B/R/Q/count outputs back into the stage, then applies sign correction at the end.
- Sits between the LPC coefficient logic (requester) and the shared divide stage.
- Provides a start/busy/done handshake, divide-by-zero detection, operand range checking and a stage-timeout watchdog.

---
 rtl/div_sequencer_if.sv | 46 ++++
 rtl/div_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Requester and divide-stage signal bundle for div_sequencer.
// slave = sequencer view, master = requester/stage environment view.
interface div_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             error;
  logic [WIDTH-1:0] stg_A;
  logic [WIDTH-1:0] stg_B;
  logic [WIDTH-1:0] stg_R;
  logic [WIDTH-1:0] stg_Q;
  logic [CW-1:0]    stg_count;
  logic             stg_v;
  logic [WIDTH-1:0] stg_A_next;
  logic [WIDTH-1:0] stg_B_next;
  logic [WIDTH-1:0] stg_R_next;
  logic [WIDTH-1:0] stg_Q_next;
  logic [CW-1:0]    stg_count_out;
  logic             stg_vout;

  modport slave (
    input  start, dividend, divisor,
    input  stg_A_next, stg_B_next, stg_R_next, stg_Q_next,
    input  stg_count_out, stg_vout,
    output busy, done, quotient, remainder,
    output div_by_zero, error,
    output stg_A, stg_B, stg_R, stg_Q, stg_count, stg_v
  );

  modport master (
    output start, dividend, divisor,
    output stg_A_next, stg_B_next, stg_R_next, stg_Q_next,
    output stg_count_out, stg_vout,
    input  busy, done, quotient, remainder,
    input  div_by_zero, error,
    input  stg_A, stg_B, stg_R, stg_Q, stg_count, stg_v
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative signed divider controller driving a shared
// radix-2 restoring divide stage over ITER passes.
module div_sequencer #(
  parameter int WIDTH     = 32,
  parameter int ITER      = WIDTH,
  parameter int STAGE_LAT = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);
  localparam int W     = WIDTH;
  localparam int CW    = $clog2(ITER);
  localparam int PW    = $clog2(ITER + 1);
  localparam int LIMIT = STAGE_LAT + TIMEOUT;
  localparam int WW    = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, WAIT, FIX, DONE
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  dvd, dvd_d, dvs, dvs_d;
  logic [W-1:0]  a, a_d, b, b_d, r, r_d, q, q_d;
  logic [PW-1:0] pass, pass_d, pass_inc;
  logic [WW-1:0] wd, wd_d;
  logic [W-1:0]  quo, quo_d, rem, rem_d;
  logic          dbz, dbz_d, err, err_d;
  logic [W-1:0]  sa, sa_d, sb, sb_d, sr, sr_d, sq, sq_d;
  logic [CW-1:0] scnt, scnt_d;
  logic          sv, sv_d;
  logic [W-1:0]  dvd_mag, dvs_mag;

  assign dvd_mag  = dvd[W-1] ? -dvd : dvd;
  assign dvs_mag  = dvs[W-1] ? -dvs : dvs;
  assign pass_inc = pass + PW'(1);

  always_comb begin
    state_d = state;
    dvd_d   = dvd;
    dvs_d   = dvs;
    a_d     = a;
    b_d     = b;
    r_d     = r;
    q_d     = q;
    pass_d  = pass;
    wd_d    = wd;
    quo_d   = quo;
    rem_d   = rem;
    dbz_d   = dbz;
    err_d   = err;
    sa_d    = sa;
    sb_d    = sb;
    sr_d    = sr;
    sq_d    = sq;
    scnt_d  = scnt;
    sv_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (dvs == '0) begin
          quo_d   = '0;
          rem_d   = dvd;
          dbz_d   = 1'b1;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (dvd == MINV || |dvs_mag[W-1:W-2]) begin
          // Magnitudes must leave headroom for the stage's shift.
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = dvd_mag;
          b_d     = dvs_mag;
          r_d     = '0;
          q_d     = '0;
          pass_d  = '0;
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = WW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.stg_vout) begin
          if (bus.stg_count_out != pass_inc[CW-1:0]) begin
            quo_d   = '0;
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = bus.stg_A_next;
            b_d     = bus.stg_B_next;
            r_d     = bus.stg_R_next;
            q_d     = bus.stg_Q_next;
            pass_d  = pass_inc;
            state_d = (pass_inc == PW'(ITER)) ? FIX : ISSUE;
          end
        end else if (wd == WW'(LIMIT - 1)) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd + WW'(1);
        end
      end
      FIX: begin
        quo_d   = (dvd[W-1] ^ dvs[W-1]) ? -q : q;
        rem_d   = dvd[W-1] ? -r : r;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stage inputs are registered so they hold between issues.
    if (state_d == ISSUE) begin
      sa_d   = a_d;
      sb_d   = b_d;
      sr_d   = r_d;
      sq_d   = q_d;
      scnt_d = pass_d[CW-1:0];
      sv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      q     <= '0;
      pass  <= '0;
      wd    <= '0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
      err   <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      sq    <= '0;
      scnt  <= '0;
      sv    <= 1'b0;
    end else begin
      state <= state_d;
      dvd   <= dvd_d;
      dvs   <= dvs_d;
      a     <= a_d;
      b     <= b_d;
      r     <= r_d;
      q     <= q_d;
      pass  <= pass_d;
      wd    <= wd_d;
      quo   <= quo_d;
      rem   <= rem_d;
      dbz   <= dbz_d;
      err   <= err_d;
      sa    <= sa_d;
      sb    <= sb_d;
      sr    <= sr_d;
      sq    <= sq_d;
      scnt  <= scnt_d;
      sv    <= sv_d;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.error       = err;
  assign bus.stg_A       = sa;
  assign bus.stg_B       = sb;
  assign bus.stg_R       = sr;
  assign bus.stg_Q       = sq;
  assign bus.stg_count   = scnt;
  assign bus.stg_v       = sv;
endmodule
